ram2p: RTL and testbench

Parametrised dual-port synchronous RAM for the RV32 FPGA core: instruction-fetch read port plus load/store data port with byte/half/word access. Generalises the fixed 32-bit word RAM:
- configurable width, depth and read latency
- byte-lane writes and sign/zero-extended sub-word loads
- misalignment and out-of-range error reporting
- valid-qualified responses through a latency pipeline

Sits between the pipeline's IF/MEM stages and the on-chip block RAM, initialised from a MIF file.

---
 rtl/ram2p.sv | 189 ++++++++++++++++++
 tb/tb_ram2p.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram2p.sv
// ram2p - parametrised dual-port synchronous RAM for the RV32 core.
//
// Port A (fetch) reads whole words. Port B (data) performs byte, half, word
// or dword loads and stores. Sub-word loads come back right-aligned and
// sign- or zero-extended.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   if_req, if_addr          fetch request and byte address
//   if_data, if_valid, if_err   fetch response
//   mem_ena, mem_rw          data request, 0 = load, 1 = store
//   mem_size, mem_unsigned   access size (1 << mem_size bytes), zero-extend flag
//   mem_addr, mem_wdata      data byte address and right-aligned store data
//   mem_rdata, mem_valid, mem_err   data response
//
// Handshake: neither port has back-pressure. A request is accepted on every
// edge where if_req / mem_ena is high. Its response appears RD_LATENCY cycles
// later. The response is a single-cycle valid pulse, and responses on each
// port come back in request order. Data outputs are 0 whenever the valid is
// low, when the response has its error flag set, and for store
// acknowledgements.
module ram2p #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 32,
  parameter int    DEPTH      = 4096,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_valid,
  output logic                  if_err,
  input  logic                  mem_ena,
  input  logic                  mem_rw,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_valid,
  output logic                  mem_err
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LB   = $clog2(NB);
  localparam int WI   = $clog2(DEPTH);
  localparam int LAST = RD_LATENCY - 1;

  // Storage has no reset. Its contents survive rst.
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- request decode ----------------
  logic [WI-1:0]         f_idx;
  logic                  f_err;
  logic [WI-1:0]         m_idx;
  logic [LB-1:0]         m_off;
  logic [2:0]            m_amask;
  logic                  m_err;
  logic [NB-1:0]         m_strb;
  logic [DATA_WIDTH-1:0] m_wsh;

  assign f_idx = if_addr[LB+WI-1:LB];
  assign f_err = (|if_addr[LB-1:0]) | (|(if_addr >> (LB + WI)));

  assign m_idx = mem_addr[LB+WI-1:LB];
  assign m_off = mem_addr[LB-1:0];
  assign m_wsh = mem_wdata << {m_off, 3'b000};

  always_comb begin
    m_amask = 3'b000;
    case (mem_size)
      2'b00:   m_amask = 3'b000;
      2'b01:   m_amask = 3'b001;
      2'b10:   m_amask = 3'b011;
      default: m_amask = 3'b111;
    endcase
  end

  // The error flag combines three cases. Misaligned means the low address
  // bits are nonzero under the size mask. Illegal size means a dword on a
  // 32-bit array. Out of range means an address bit above the word index is
  // set.
  assign m_err = (|(mem_addr[2:0] & m_amask))
               | ((mem_size == 2'b11) && (DATA_WIDTH == 32))
               | (|(mem_addr >> (LB + WI)));

  // A lane is strobed when it falls inside [off, off + bytes).
  always_comb begin
    m_strb = '0;
    for (int b = 0; b < NB; b++) begin
      m_strb[b] = (b >= int'(m_off)) && (b < int'(m_off) + (1 << mem_size));
    end
  end

  // ---------------- array and read-data pipeline ----------------
  // The stage-0 read registers sit in the same block as the writes, so a
  // fetch of a word being stored in the same cycle returns the old contents.
  logic [DATA_WIDTH-1:0] f_dp [RD_LATENCY];
  logic [DATA_WIDTH-1:0] m_dp [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (mem_ena && mem_rw && !m_err) begin
      for (int b = 0; b < NB; b++) begin
        if (m_strb[b]) mem[m_idx][8*b +: 8] <= m_wsh[8*b +: 8];
      end
    end
    if (if_req)              f_dp[0] <= mem[f_idx];
    if (mem_ena && !mem_rw)  m_dp[0] <= mem[m_idx];
    for (int s = 1; s < RD_LATENCY; s++) begin
      f_dp[s] <= f_dp[s-1];
      m_dp[s] <= m_dp[s-1];
    end
  end

  // ---------------- response control pipeline ----------------
  logic          f_v  [RD_LATENCY];
  logic          f_e  [RD_LATENCY];
  logic          m_v  [RD_LATENCY];
  logic          m_e  [RD_LATENCY];
  logic          m_w  [RD_LATENCY];
  logic          m_u  [RD_LATENCY];
  logic [1:0]    m_sz [RD_LATENCY];
  logic [LB-1:0] m_o  [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        f_v[s]  <= 1'b0;
        f_e[s]  <= 1'b0;
        m_v[s]  <= 1'b0;
        m_e[s]  <= 1'b0;
        m_w[s]  <= 1'b0;
        m_u[s]  <= 1'b0;
        m_sz[s] <= 2'b00;
        m_o[s]  <= '0;
      end
    end else begin
      f_v[0]  <= if_req;
      f_e[0]  <= if_req & f_err;
      m_v[0]  <= mem_ena;
      m_e[0]  <= mem_ena & m_err;
      m_w[0]  <= mem_rw;
      m_u[0]  <= mem_unsigned;
      m_sz[0] <= mem_size;
      m_o[0]  <= m_off;
      for (int s = 1; s < RD_LATENCY; s++) begin
        f_v[s]  <= f_v[s-1];
        f_e[s]  <= f_e[s-1];
        m_v[s]  <= m_v[s-1];
        m_e[s]  <= m_e[s-1];
        m_w[s]  <= m_w[s-1];
        m_u[s]  <= m_u[s-1];
        m_sz[s] <= m_sz[s-1];
        m_o[s]  <= m_o[s-1];
      end
    end
  end

  // ---------------- final stage: lane shift and extension ----------------
  logic [DATA_WIDTH-1:0] m_shift;
  logic [DATA_WIDTH-1:0] lo_mask;
  logic [DATA_WIDTH-1:0] sign_mask;
  logic [DATA_WIDTH-1:0] m_ext;
  logic                  m_sign;
  int                    nbits;

  always_comb begin
    m_shift = m_dp[LAST] >> {m_o[LAST], 3'b000};
    nbits   = 8 << m_sz[LAST];
    if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
    lo_mask   = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - nbits);
    // The top bit of the loaded field is the lo_mask bit not kept by lo_mask >> 1.
    sign_mask = lo_mask ^ (lo_mask >> 1);
    m_sign    = |(m_shift & sign_mask);
    // A full-width load has an empty ~lo_mask, so mem_unsigned has no effect.
    m_ext     = (m_shift & lo_mask) | ((!m_u[LAST] && m_sign) ? ~lo_mask : '0);
  end

  assign if_valid  = f_v[LAST];
  assign if_err    = f_e[LAST];
  assign if_data   = (f_v[LAST] && !f_e[LAST]) ? f_dp[LAST] : '0;
  assign mem_valid = m_v[LAST];
  assign mem_err   = m_e[LAST];
  assign mem_rdata = (m_v[LAST] && !m_e[LAST] && !m_w[LAST]) ? m_ext : '0;

endmodule

// File: tb/tb_ram2p.sv
// tb_ram2p - directed bench for ram2p.
// Three instances share one stimulus bus:
//   u_a  32-bit, latency 1
//   u_b  32-bit, latency 3
//   u_c  64-bit, latency 1
// Each step checks the outputs of the instance that step targets.
module tb_ram2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_ena;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;

  logic [31:0] a_if_data, a_mem_rdata;
  logic        a_if_valid, a_if_err, a_mem_valid, a_mem_err;
  logic [31:0] b_if_data, b_mem_rdata;
  logic        b_if_valid, b_if_err, b_mem_valid, b_mem_err;
  logic [63:0] c_if_data, c_mem_rdata;
  logic        c_if_valid, c_if_err, c_mem_valid, c_mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram2p #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_data(a_if_data), .if_valid(a_if_valid), .if_err(a_if_err),
    .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata[31:0]),
    .mem_rdata(a_mem_rdata), .mem_valid(a_mem_valid), .mem_err(a_mem_err)
  );

  ram2p #(.DATA_WIDTH(32), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_data(b_if_data), .if_valid(b_if_valid), .if_err(b_if_err),
    .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata[31:0]),
    .mem_rdata(b_mem_rdata), .mem_valid(b_mem_valid), .mem_err(b_mem_err)
  );

  ram2p #(.DATA_WIDTH(64), .RD_LATENCY(1)) u_c (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_data(c_if_data), .if_valid(c_if_valid), .if_err(c_if_err),
    .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(c_mem_rdata), .mem_valid(c_mem_valid), .mem_err(c_mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents one data-port request for a single edge.
  task automatic op(input logic rw, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [63:0] wdata);
    mem_ena = 1'b1; mem_rw = rw; mem_size = size; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wdata;
    @(negedge clk);
    mem_ena = 1'b0; mem_rw = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_ena = 1'b0; mem_rw = 1'b0;
    mem_size = 2'b00; mem_unsigned = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_if_valid", 64'(a_if_valid), 64'd0);
    chk("rst_a_if_err", 64'(a_if_err), 64'd0);
    chk("rst_a_if_data", 64'(a_if_data), 64'd0);
    chk("rst_a_mem_valid", 64'(a_mem_valid), 64'd0);
    chk("rst_a_mem_err", 64'(a_mem_err), 64'd0);
    chk("rst_a_mem_rdata", 64'(a_mem_rdata), 64'd0);
    chk("rst_b_mem_valid", 64'(b_mem_valid), 64'd0);
    chk("rst_c_mem_valid", 64'(c_mem_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- u_a: basic store / load, latency 1 ----
    op(1'b1, 2'b10, 1'b0, 32'h10, 64'hDEADBEEF);
    chk("a_st_valid", 64'(a_mem_valid), 64'd1);
    chk("a_st_rdata", 64'(a_mem_rdata), 64'd0);
    chk("a_st_err", 64'(a_mem_err), 64'd0);
    @(negedge clk);
    chk("a_idle_valid", 64'(a_mem_valid), 64'd0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 64'd0);
    chk("a_ldw_valid", 64'(a_mem_valid), 64'd1);
    chk("a_ldw_data", 64'(a_mem_rdata), 64'hDEADBEEF);
    chk("a_ldw_err", 64'(a_mem_err), 64'd0);
    op(1'b1, 2'b00, 1'b0, 32'h11, 64'h5A);
    chk("a_stb_valid", 64'(a_mem_valid), 64'd1);
    op(1'b0, 2'b00, 1'b0, 32'h13, 64'd0);
    chk("a_ldb_s", 64'(a_mem_rdata), 64'hFFFFFFDE);
    op(1'b0, 2'b00, 1'b1, 32'h13, 64'd0);
    chk("a_ldb_u", 64'(a_mem_rdata), 64'h000000DE);
    op(1'b0, 2'b01, 1'b1, 32'h10, 64'd0);
    chk("a_ldh_u", 64'(a_mem_rdata), 64'h00005AEF);
    op(1'b0, 2'b01, 1'b0, 32'h12, 64'd0);
    chk("a_ldh_s", 64'(a_mem_rdata), 64'hFFFFDEAD);
    op(1'b0, 2'b10, 1'b1, 32'h10, 64'd0);
    chk("a_ldw_merged", 64'(a_mem_rdata), 64'hDEAD5AEF);

    // ---- u_a: error cases ----
    op(1'b1, 2'b01, 1'b0, 32'h13, 64'hFFFF);
    chk("a_sth_mis_err", 64'(a_mem_err), 64'd1);
    chk("a_sth_mis_valid", 64'(a_mem_valid), 64'd1);
    chk("a_sth_mis_rdata", 64'(a_mem_rdata), 64'd0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 64'd0);
    chk("a_unchanged", 64'(a_mem_rdata), 64'hDEAD5AEF);
    op(1'b0, 2'b10, 1'b0, 32'h4000, 64'd0);
    chk("a_oor_err", 64'(a_mem_err), 64'd1);
    chk("a_oor_rdata", 64'(a_mem_rdata), 64'd0);
    op(1'b0, 2'b10, 1'b0, 32'h12, 64'd0);
    chk("a_ldw_mis_err", 64'(a_mem_err), 64'd1);
    op(1'b0, 2'b11, 1'b0, 32'h8, 64'd0);
    chk("a_dword_illegal", 64'(a_mem_err), 64'd1);
    fetch(32'h4002);
    chk("a_if_err", 64'(a_if_err), 64'd1);
    chk("a_if_err_valid", 64'(a_if_valid), 64'd1);
    chk("a_if_err_data", 64'(a_if_data), 64'd0);
    fetch(32'h10);
    chk("a_if_ok_err", 64'(a_if_err), 64'd0);
    chk("a_if_ok_data", 64'(a_if_data), 64'hDEAD5AEF);

    // ---- u_a: same-word collision returns old data ----
    op(1'b1, 2'b10, 1'b0, 32'h20, 64'h0);
    mem_ena = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_addr = 32'h20;
    mem_wdata = 64'h11111111; if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    mem_ena = 1'b0; mem_rw = 1'b0; if_req = 1'b0;
    chk("a_coll_old", 64'(a_if_data), 64'h0);
    chk("a_coll_st_valid", 64'(a_mem_valid), 64'd1);
    fetch(32'h20);
    chk("a_coll_new", 64'(a_if_data), 64'h11111111);

    // ---- u_b: latency 3, back-to-back loads ----
    for (int i = 0; i < 4; i++) op(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), 64'hA0000000 + 64'(i));
    repeat (4) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      mem_ena = (c < 4); mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h100 + 32'(4 * c);
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("b_lat_valid_%0d", c), 64'(b_mem_valid), 64'd1);
        chk($sformatf("b_lat_data_%0d", c), 64'(b_mem_rdata), 64'hA0000000 + 64'(c - 2));
      end else begin
        chk($sformatf("b_lat_idle_%0d", c), 64'(b_mem_valid), 64'd0);
      end
    end
    mem_ena = 1'b0;

    // ---- u_b: reset while a load is in flight ----
    mem_ena = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h100;
    @(negedge clk);
    mem_ena = 1'b0;
    rst = 1'b1;
    #1;
    chk("b_rst_mem_valid", 64'(b_mem_valid), 64'd0);
    chk("b_rst_mem_rdata", 64'(b_mem_rdata), 64'd0);
    chk("b_rst_mem_err", 64'(b_mem_err), 64'd0);
    chk("b_rst_if_valid", 64'(b_if_valid), 64'd0);
    chk("b_rst_if_data", 64'(b_if_data), 64'd0);
    chk("b_rst_if_err", 64'(b_if_err), 64'd0);
    repeat (2) @(negedge clk);
    chk("b_rst_hold_valid", 64'(b_mem_valid), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b_drop_%0d", c), 64'(b_mem_valid), 64'd0);
    end
    op(1'b0, 2'b10, 1'b0, 32'h104, 64'd0);
    repeat (2) @(negedge clk);
    chk("b_post_rst_valid", 64'(b_mem_valid), 64'd1);
    chk("b_post_rst_data", 64'(b_mem_rdata), 64'hA0000001);
    op(1'b0, 2'b10, 1'b0, 32'h10, 64'd0);
    chk("a_post_rst_data", 64'(a_mem_rdata), 64'hDEAD5AEF);

    // ---- u_c: 64-bit words ----
    op(1'b1, 2'b11, 1'b0, 32'h8, 64'h0123456789ABCDEF);
    chk("c_std_valid", 64'(c_mem_valid), 64'd1);
    chk("c_std_err", 64'(c_mem_err), 64'd0);
    op(1'b0, 2'b10, 1'b0, 32'hC, 64'd0);
    chk("c_ldw_hi", c_mem_rdata, 64'h0000000001234567);
    op(1'b0, 2'b10, 1'b0, 32'h8, 64'd0);
    chk("c_ldw_lo_s", c_mem_rdata, 64'hFFFFFFFF89ABCDEF);
    op(1'b0, 2'b10, 1'b1, 32'h8, 64'd0);
    chk("c_ldw_lo_u", c_mem_rdata, 64'h0000000089ABCDEF);
    op(1'b0, 2'b00, 1'b0, 32'hF, 64'd0);
    chk("c_ldb_top", c_mem_rdata, 64'h0000000000000001);
    op(1'b0, 2'b11, 1'b1, 32'h8, 64'd0);
    chk("c_ldd", c_mem_rdata, 64'h0123456789ABCDEF);
    op(1'b0, 2'b11, 1'b0, 32'h4, 64'd0);
    chk("c_ldd_mis_err", 64'(c_mem_err), 64'd1);
    chk("c_ldd_mis_data", c_mem_rdata, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
